uart_cmd_driver: RTL and testbench

Host-side initiator for the 7-bit UART command bus (io_in7). Accepts byte-level requests over a valid/ready handshake and serialises them into timed command words of the form {payload[4:0], cmd[1:0]}. Used as the bench and FPGA-side driver that exercises the UART core's command decoder. Handles DATA, CONFIG, PREDIV and the dedicated RESET command.

---
 rtl/uart_cmd_driver.sv | 212 +++++++++++++++++++++
 tb/tb_uart_cmd_driver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_driver.sv
// ---------------------------------------------------------------------------
// uart_cmd_driver
//
// Host-side initiator for the 7-bit UART command bus (io_in7). A request
// (op + payload byte) taken over a valid/ready handshake is turned into a
// sequence of timed command words {payload[4:0], cmd[1:0]}. Each command word
// is held for HOLD_CYCLES cycles. After each word, the idle word 7'h03 is held
// for GAP_CYCLES cycles.
//
// Optional feature macro: UART_CMD_DRIVER_CHECK_EN
//   When this macro is defined, DATA and PREDIV transactions get an extra CHECK
//   beat, {1, lo^hi, 2'b11}, followed by an idle gap.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   req_valid    in   request present
//   req_ready    out  driver can accept a request (high only when idle)
//   req_op       in   0=DATA, 1=CONFIG, 2=PREDIV, 3=RESET
//   req_payload  in   byte for DATA/PREDIV, [3:0] for CONFIG, ignored for RESET
//   bus_out      out  command word to the device's io_in7 (registered)
//   busy         out  transaction in progress
//   done         out  one-cycle pulse when a transaction completes
// ---------------------------------------------------------------------------
module uart_cmd_driver #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic [7:0] req_payload,
   output logic [6:0] bus_out,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] OP_DATA   = 2'd0;
   localparam logic [1:0] OP_CONFIG = 2'd1;
   localparam logic [1:0] OP_PREDIV = 2'd2;
   localparam logic [1:0] OP_RESET  = 2'd3;

   localparam logic [6:0] IDLE_WORD = 7'h03;

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_BEAT0 = 3'd1,
      S_GAP0  = 3'd2,
      S_BEAT1 = 3'd3,
`ifdef UART_CMD_DRIVER_CHECK_EN
      S_GAP1  = 3'd4,
      S_CHECK = 3'd5,
      S_GAPC  = 3'd6
`else
      S_GAP1  = 3'd4
`endif
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       op_q;
   logic [7:0]       pay_q;
   logic [6:0]       bus_nxt;
   logic             done_nxt;

   logic       accept;
   logic       two_beat;
   logic [1:0] cur_op;
   logic [7:0] cur_pay;
   logic       cnt_zero;

   // First word of every transaction. RESET uses the reserved payload 5'b11000.
   // CONFIG keeps bit 4 clear, so it can never alias that payload.
   function automatic logic [6:0] beat0_word(input logic [1:0] op, input logic [7:0] pay);
      logic [6:0] w;
      case (op)
         OP_DATA:   w = {1'b0, pay[3:0], 2'b00};
         OP_CONFIG: w = {1'b0, pay[3:0], 2'b01};
         OP_PREDIV: w = {1'b0, pay[3:0], 2'b10};
         default:   w = {5'b11000, 2'b01};
      endcase
      return w;
   endfunction

   // The high nibble uses the same cmd code as beat 0, with bit 4 set.
   function automatic logic [6:0] beat1_word(input logic [1:0] op, input logic [7:0] pay);
      return {1'b1, pay[7:4], op};
   endfunction

`ifdef UART_CMD_DRIVER_CHECK_EN
   function automatic logic [6:0] check_word(input logic [7:0] pay);
      return {1'b1, pay[3:0] ^ pay[7:4], 2'b11};
   endfunction
`endif

   assign accept    = req_valid && (state == S_IDLE);
   assign two_beat  = (op_q == OP_DATA) || (op_q == OP_PREDIV);
   assign cnt_zero  = (cnt == '0);
   // In the accept cycle, the word for beat 0 comes straight from the request.
   // It does not use the latched copy.
   assign cur_op    = accept ? req_op : op_q;
   assign cur_pay   = accept ? req_payload : pay_q;

   assign req_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   // State, counter and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bus_out <= IDLE_WORD;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bus_out <= bus_nxt;
         done    <= done_nxt;
      end
   end

   // The request is latched without a reset, because it is only read after an
   // accept.
   always_ff @(posedge clk) begin
      if (!reset && accept) begin
         op_q  <= req_op;
         pay_q <= req_payload;
      end
   end

   // Next-state and counter
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (req_valid) state_nxt = S_BEAT0;
         end
         S_BEAT0: begin
            if (cnt_zero) begin
               if (HAS_GAP)       state_nxt = S_GAP0;
               else if (two_beat) state_nxt = S_BEAT1;
               else               state_nxt = S_IDLE;
            end
         end
         S_GAP0: begin
            if (cnt_zero) state_nxt = two_beat ? S_BEAT1 : S_IDLE;
         end
         S_BEAT1: begin
            if (cnt_zero) begin
`ifdef UART_CMD_DRIVER_CHECK_EN
               state_nxt = HAS_GAP ? S_GAP1 : S_CHECK;
`else
               state_nxt = HAS_GAP ? S_GAP1 : S_IDLE;
`endif
            end
         end
         S_GAP1: begin
`ifdef UART_CMD_DRIVER_CHECK_EN
            if (cnt_zero) state_nxt = S_CHECK;
`else
            if (cnt_zero) state_nxt = S_IDLE;
`endif
         end
`ifdef UART_CMD_DRIVER_CHECK_EN
         S_CHECK: begin
            if (cnt_zero) state_nxt = HAS_GAP ? S_GAPC : S_IDLE;
         end
         S_GAPC: begin
            if (cnt_zero) state_nxt = S_IDLE;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase

      // The counter reloads only when the state changes, so it never wraps.
      if (state_nxt != state) begin
         case (state_nxt)
            S_IDLE: cnt_nxt = '0;
            S_GAP0, S_GAP1: cnt_nxt = GAP_LOAD;
`ifdef UART_CMD_DRIVER_CHECK_EN
            S_GAPC: cnt_nxt = GAP_LOAD;
`endif
            default: cnt_nxt = HOLD_LOAD;
         endcase
      end else if (!cnt_zero) begin
         cnt_nxt = cnt - 1'b1;
      end
   end

   // Output words, based on the state being entered
   always_comb begin
      bus_nxt  = IDLE_WORD;
      done_nxt = (state_nxt == S_IDLE) && (state != S_IDLE);
      case (state_nxt)
         S_BEAT0: bus_nxt = beat0_word(cur_op, cur_pay);
         S_BEAT1: bus_nxt = beat1_word(cur_op, cur_pay);
`ifdef UART_CMD_DRIVER_CHECK_EN
         S_CHECK: bus_nxt = check_word(cur_pay);
`endif
         default: bus_nxt = IDLE_WORD;
      endcase
   end

endmodule

// File: tb/tb_uart_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_driver
//
// Directed bench for uart_cmd_driver. Instance u_dut uses HOLD=4, GAP=2.
// Instance u_dut0 uses HOLD=4, GAP=0. Both instances share the clock and the
// reset. Expected words are hand-encoded constants.
// ---------------------------------------------------------------------------
module tb_uart_cmd_driver;

   logic       clk = 1'b0;
   logic       reset;

   logic       req_valid, req_ready, busy, done;
   logic [1:0] req_op;
   logic [7:0] req_payload;
   logic [6:0] bus_out;

   logic       req_valid0, req_ready0, busy0, done0;
   logic [1:0] req_op0;
   logic [7:0] req_payload0;
   logic [6:0] bus_out0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_cmd_driver #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_payload (req_payload),
      .bus_out     (bus_out),
      .busy        (busy),
      .done        (done)
   );

   uart_cmd_driver #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .CNT_W(8)) u_dut0 (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid0),
      .req_ready   (req_ready0),
      .req_op      (req_op0),
      .req_payload (req_payload0),
      .bus_out     (bus_out0),
      .busy        (busy0),
      .done        (done0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks that the selected instance holds word w (with done low) for n cycles.
   task automatic expect_bus(input bit s, input string tag, input logic [6:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         chk(tag, {1'b0, (s ? bus_out0 : bus_out)}, {1'b0, w});
         chk({tag, "_done"}, {7'b0, (s ? done0 : done)}, 8'h00);
         tick();
      end
   endtask

   // Checks the single completion cycle of the selected instance.
   task automatic expect_done(input bit s, input string tag);
      chk({tag, "_done"},  {7'b0, (s ? done0 : done)}, 8'h01);
      chk({tag, "_ready"}, {7'b0, (s ? req_ready0 : req_ready)}, 8'h01);
      chk({tag, "_busy"},  {7'b0, (s ? busy0 : busy)}, 8'h00);
      chk({tag, "_bus"},   {1'b0, (s ? bus_out0 : bus_out)}, 8'h03);
   endtask

   initial begin
      // 1: Reset with a request pending
      reset        = 1'b1;
      req_valid    = 1'b1;
      req_op       = 2'd0;
      req_payload  = 8'hA5;
      req_valid0   = 1'b0;
      req_op0      = 2'd0;
      req_payload0 = 8'h00;
      tick();
      tick();
      chk("rst_bus",   {1'b0, bus_out}, 8'h03);
      chk("rst_ready", {7'b0, req_ready}, 8'h01);
      chk("rst_busy",  {7'b0, busy}, 8'h00);
      chk("rst_done",  {7'b0, done}, 8'h00);
      chk("rst_bus0",  {1'b0, bus_out0}, 8'h03);
      req_valid = 1'b0;
      reset     = 1'b0;
      tick();
      chk("rst_noacc_busy", {7'b0, busy}, 8'h00);
      chk("rst_noacc_bus",  {1'b0, bus_out}, 8'h03);

      // 2: DATA 0xA5, accepted at edge 0
      req_valid   = 1'b1;
      req_op      = 2'd0;
      req_payload = 8'hA5;
      tick();
      req_valid = 1'b0;
      chk("d_busy",  {7'b0, busy}, 8'h01);
      chk("d_ready", {7'b0, req_ready}, 8'h00);
      expect_bus(0, "d_beat0", 7'h14, 4);
      expect_bus(0, "d_gap0",  7'h03, 2);
      expect_bus(0, "d_beat1", 7'h68, 4);
      expect_bus(0, "d_gap1",  7'h03, 2);
`ifdef UART_CMD_DRIVER_CHECK_EN
      expect_bus(0, "d_check", 7'h7F, 4);
      expect_bus(0, "d_gapc",  7'h03, 2);
`endif
      expect_done(0, "d_end");
      tick();
      chk("d_pulse", {7'b0, done}, 8'h00);

      // 3: RESET op, then CONFIG 0x5 and CONFIG 0xF
      req_valid = 1'b1;
      req_op    = 2'd3;
      tick();
      req_valid = 1'b0;
      expect_bus(0, "r_beat", 7'h61, 4);
      expect_bus(0, "r_gap",  7'h03, 2);
      expect_done(0, "r_end");

      req_valid   = 1'b1;
      req_op      = 2'd1;
      req_payload = 8'h05;
      tick();
      req_valid = 1'b0;
      expect_bus(0, "c5_beat", 7'h15, 4);
      expect_bus(0, "c5_gap",  7'h03, 2);
      expect_done(0, "c5_end");

      req_valid   = 1'b1;
      req_payload = 8'hFF;
      tick();
      req_valid = 1'b0;
      expect_bus(0, "cf_beat", 7'h3D, 4);
      expect_bus(0, "cf_gap",  7'h03, 2);
      expect_done(0, "cf_end");
      tick();

      // 4: PREDIV 0x3C with no gaps, then a back-to-back DATA 0x00
      req_valid0   = 1'b1;
      req_op0      = 2'd2;
      req_payload0 = 8'h3C;
      tick();
      req_op0      = 2'd0;
      req_payload0 = 8'h00;
      expect_bus(1, "p_beat0", 7'h32, 4);
      expect_bus(1, "p_beat1", 7'h4E, 4);
`ifdef UART_CMD_DRIVER_CHECK_EN
      expect_bus(1, "p_check", 7'h7F, 4);
`endif
      expect_done(1, "p_end");
      tick();
      req_valid0 = 1'b0;
      chk("b2b_busy", {7'b0, busy0}, 8'h01);
      expect_bus(1, "b2b_beat0", 7'h00, 4);
      expect_bus(1, "b2b_beat1", 7'h40, 4);
`ifdef UART_CMD_DRIVER_CHECK_EN
      expect_bus(1, "b2b_check", 7'h43, 4);
`endif
      expect_done(1, "b2b_end");
      tick();

      // 5: Reset during the 2nd cycle of beat 1 of DATA 0xA5
      req_valid   = 1'b1;
      req_op      = 2'd0;
      req_payload = 8'hA5;
      tick();
      req_valid = 1'b0;
      expect_bus(0, "m_beat0", 7'h14, 4);
      expect_bus(0, "m_gap0",  7'h03, 2);
      expect_bus(0, "m_beat1", 7'h68, 1);
      chk("m_beat1_2", {1'b0, bus_out}, 8'h68);
      reset       = 1'b1;
      req_valid   = 1'b1;
      req_op      = 2'd1;
      req_payload = 8'h05;
      tick();
      chk("m_rst_bus",  {1'b0, bus_out}, 8'h03);
      chk("m_rst_done", {7'b0, done}, 8'h00);
      chk("m_rst_busy", {7'b0, busy}, 8'h00);
      reset = 1'b0;
      tick();
      req_valid = 1'b0;
      chk("m_new_busy", {7'b0, busy}, 8'h01);
      expect_bus(0, "m_new_beat", 7'h15, 4);
      expect_bus(0, "m_new_gap",  7'h03, 2);
      expect_done(0, "m_new_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
